// File: rtl/rvx10_uart_mmio.sv
// rvx10_uart_mmio: store-driven UART transmitter for the RVX10 data-memory bus.
// Bytes written to TXDATA are queued in a small FIFO and sent as 8N1 frames,
// LSB first. STATUS reports busy/full/empty/overflow and the FIFO fill level.
// Register reads are combinational so the core can mux them with dmem data.
module rvx10_uart_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MmioHit,
  output logic        tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             ovf_q;

  // Serializer state
  state_t           state_q;
  logic [7:0]       shift_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]       bit_idx_q;
  logic             tx_q;

  // Bus decode and FIFO handshakes
  logic       sel_status;
  logic       push;
  logic       push_ok;
  logic       pop;
  logic       ovf_clr;
  logic       fifo_empty;
  logic       fifo_full;
  logic       busy;
  logic       baud_done;
  logic [7:0] head_byte;

  // Byte lanes and sub-word address bits the register map never looks at
  logic unused_bits;
  assign unused_bits = ^{ALUResult[1:0], WriteData[31:8]};

  assign MmioHit    = (ALUResult[31:3] == BASE_ADDR[31:3]);
  assign sel_status = ALUResult[2];
  assign push       = MemWrite & MmioHit & ~sel_status;
  assign ovf_clr    = MemWrite & MmioHit &  sel_status;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign busy       = (state_q != ST_IDLE);

  // The serializer drains the head only while idle; a pop frees a slot in the
  // same cycle, so a push into a full FIFO is still accepted then.
  assign pop       = (state_q == ST_IDLE) & ~fifo_empty;
  assign push_ok   = push & (~fifo_full | pop);
  assign head_byte = fifo_mem[rd_ptr_q];
  assign baud_done = (baud_q == BAUD_LAST);

  // Next fill level: push and pop together leave it unchanged
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO data array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= WriteData[7:0];
    end
  end

  // FIFO pointers, fill level and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      if (push && !push_ok) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // 8N1 frame sequencer with a registered serial output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      baud_q    <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q      <= 1'b1;
          baud_q    <= '0;
          bit_idx_q <= '0;
          if (pop) begin
            shift_q <= head_byte;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= ST_DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          baud_q  <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx = tx_q;

  // Register read mux; TXDATA and non-hit accesses read as zero
  always_comb begin
    ReadData = '0;
    if (MmioHit && sel_status) begin
      ReadData[0]          = busy;
      ReadData[1]          = fifo_full;
      ReadData[2]          = fifo_empty;
      ReadData[3]          = ovf_q;
      ReadData[8 +: CNT_W] = count_q;
    end
  end

endmodule

// File: tb/tb_rvx10_uart_mmio.sv
// tb_rvx10_uart_mmio: drives directed and random bus traffic into the UART
// and compares MmioHit, ReadData and tx every cycle against a frame-level
// reference built from a byte queue and bit-position arithmetic.
module tb_rvx10_uart_mmio;

  localparam int          C    = 4;
  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MmioHit;
  logic        tx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: pending bytes, sticky overflow, current frame start/byte
  logic [7:0] mq[$];
  bit         m_ovf;
  int         m_fstart;
  logic [7:0] m_fbyte;

  always #5 clk = ~clk;

  rvx10_uart_mmio #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .MmioHit  (MmioHit),
    .tx       (tx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_in_frame();
    return (m_fstart >= 0) && (cyc >= m_fstart) && (cyc < m_fstart + 10 * C);
  endfunction

  function automatic bit m_pop_now();
    return !m_in_frame() && (mq.size() > 0);
  endfunction

  function automatic logic m_tx();
    int p;
    if (!m_in_frame()) return 1'b1;
    p = (cyc - m_fstart) / C;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return m_fbyte[p-1];
  endfunction

  function automatic bit m_hit(input logic [31:0] addr);
    return (addr & 32'hFFFF_FFF8) == BASE;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] addr);
    logic [31:0] r;
    r = '0;
    if (m_hit(addr) && addr[2]) begin
      r[0]     = m_in_frame();
      r[1]     = (mq.size() == D);
      r[2]     = (mq.size() == 0);
      r[3]     = m_ovf;
      r[15:8]  = 8'(mq.size());
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_load_addr();
    case ($urandom_range(0, 4))
      0:       return BASE;
      1:       return BASE + 32'd4;
      2:       return BASE + 32'd8;
      3:       return 32'h0000_0100;
      default: return BASE + 32'd4 + 32'($urandom_range(0, 3));
    endcase
  endfunction

  // One bus cycle: drive, check mid-cycle, advance the model, cross the edge
  task automatic step(input logic rst, input logic we, input logic [31:0] addr,
                      input logic [31:0] data);
    bit hit;
    reset     = rst;
    MemWrite  = we;
    ALUResult = addr;
    WriteData = data;
    #2;
    hit = m_hit(addr);
    chk("hit", {31'b0, MmioHit}, {31'b0, hit});
    chk("rdata", ReadData, m_rdata(addr));
    chk("tx", {31'b0, tx}, {31'b0, m_tx()});
    if (we) $display("store cyc=%0d addr=%h data=%h hit=%0d rst=%0d", cyc, addr, data, hit, rst);
    if (rst) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_fstart = -1;
    end else begin
      if (m_pop_now()) begin
        m_fbyte  = mq.pop_front();
        m_fstart = cyc + 1;
      end
      if (we && hit && !addr[2]) begin
        if (mq.size() < D) mq.push_back(data[7:0]);
        else m_ovf = 1'b1;
      end
      if (we && hit && addr[2]) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rand_load_addr(), 32'h0);
  endtask

  initial begin
    int k;
    int r;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    ALUResult = '0;
    WriteData = '0;
    mq.delete();
    m_ovf    = 1'b0;
    m_fstart = -1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state: STATUS reads exactly 4, line idle
    reset     = 1'b0;
    ALUResult = BASE + 32'd4;
    #2;
    chk("reset_status", ReadData, 32'h0000_0004);
    chk("reset_hit", {31'b0, MmioHit}, 32'h1);
    chk("reset_tx", {31'b0, tx}, 32'h1);
    step(1'b0, 1'b0, BASE + 32'd4, 32'h0);

    // Single frame of 0xA5
    step(1'b0, 1'b1, BASE, 32'h0000_00A5);
    idle(45);

    // Six back-to-back stores: one pops early, four queue, the sixth overflows
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, BASE, 32'(i));
    step(1'b0, 1'b0, BASE + 32'd4, 32'h0);
    chk("ovf_full_status", ReadData & 32'h0000_000A, 32'h0000_000A);
    step(1'b0, 1'b1, BASE + 32'd4, $urandom);
    step(1'b0, 1'b0, BASE + 32'd4, 32'h0);
    idle(5 * (10 * C + 1) + 10);

    // Fill the FIFO, then push exactly in an idle pop cycle
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, BASE, 32'h10 + 32'(i));
    k = 0;
    while (!m_pop_now() && k < 200) begin
      idle(1);
      k++;
    end
    chk("wait_pop", {31'b0, m_pop_now()}, 32'h1);
    step(1'b0, 1'b1, BASE, 32'h0000_005A);
    step(1'b0, 1'b0, BASE + 32'd4, 32'h0);
    chk("push_pop_status", ReadData & 32'h0000_FF0A, 32'h0000_0402);
    idle(5 * (10 * C + 1) + 10);

    // Reset in the middle of the data bits with two bytes still queued
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, BASE, 32'hC3 + 32'(i));
    k = 0;
    while (!(m_in_frame() && cyc >= m_fstart + 3 * C) && k < 100) begin
      idle(1);
      k++;
    end
    chk("wait_data", {31'b0, m_in_frame()}, 32'h1);
    step(1'b1, 1'b0, BASE + 32'd4, 32'h0);
    ALUResult = BASE + 32'd4;
    #2;
    chk("post_reset_status", ReadData, 32'h0000_0004);
    chk("post_reset_tx", {31'b0, tx}, 32'h1);
    idle(60);

    // Non-hit store and load leave the block untouched
    step(1'b0, 1'b1, 32'hFFFF_0008, 32'h0000_0077);
    step(1'b0, 1'b0, 32'h0000_0100, 32'h0);
    step(1'b0, 1'b0, BASE + 32'd4, 32'h0);
    idle(3);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6)       step(1'b0, 1'b1, BASE + 32'($urandom_range(0, 3)), $urandom);
      else if (r < 7)  step(1'b0, 1'b1, BASE + 32'd4 + 32'($urandom_range(0, 3)), $urandom);
      else if (r < 9)  step(1'b0, 1'b1, $urandom & 32'h7FFF_FFFF, $urandom);
      else if (r < 10 && $urandom_range(0, 9) == 0) step(1'b1, 1'b0, rand_load_addr(), 32'h0);
      else             step(1'b0, 1'b0, rand_load_addr(), 32'h0);
    end
    idle(10 * C * (D + 1) + 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvx10_uart_mmio.md
Name: rvx10_uart_mmio

Overview:
Memory-mapped UART transmitter on the data-memory side of the RVX10 single-cycle core. It consumes the core's store bus (MemWrite, ALUResult as address, WriteData) and buffers bytes in a small FIFO. A serializer shifts the bytes out as 8N1 frames. It also returns status words combinationally on ReadData, so the top-level can mux them with data memory in the same cycle.

Parameters:
BASE_ADDR, 32'hFFFF_0000, byte address of register block; must be 8-byte aligned.
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
FIFO_DEPTH, 4, TX FIFO entries; power of two, at least 2.

Ports:
clk  input  1  core clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
MemWrite  input  1  store strobe from the core.
ALUResult  input  32  load/store byte address from the core.
WriteData  input  32  store data from the core.
ReadData  output  32  register read data; combinational; 0 when MmioHit=0.
MmioHit  output  1  combinational; 1 when ALUResult[31:3]==BASE_ADDR[31:3]; the top-level uses it to select ReadData and to suppress the dmem write.
tx  output  1  serial line; idles high.

Behaviour:
- Register map. ALUResult[2]=0 selects TXDATA; ALUResult[2]=1 selects STATUS. ALUResult[1:0] is ignored.
- Write TXDATA (MemWrite & MmioHit & sel=0): push WriteData[7:0] into the FIFO.
- Read TXDATA: returns 0.
- Write STATUS: clears the sticky overflow bit; the data value is ignored.
- Read STATUS bits:
  - [0] busy: FSM not IDLE.
  - [1] full.
  - [2] empty.
  - [3] overflow, sticky.
  - [15:8] FIFO count.
  - all other bits 0.
- Full push: a push when the FIFO is full and no pop occurs in the same cycle is dropped, and overflow is set.
- Push with pop: a push in the same cycle as a pop is always accepted; count is unchanged.
- Simultaneous overflow set and STATUS-write clear cannot occur, because one store selects exactly one register.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START on the next edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles. After the 8th bit, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Timing:
  - A frame lasts exactly 10*CLKS_PER_BIT cycles from the first START cycle.
  - Back-to-back frames have exactly 1 IDLE cycle (tx=1) between the end of STOP and the next START.
  - First-byte latency: store at edge N; the FIFO is non-empty during cycle N+1 (IDLE, pop); START begins at edge N+2.
- Counters:
  - The baud counter is wide enough for CLKS_PER_BIT-1 and resets to 0 on every state entry.
  - The bit index counts 0..7.
  - FIFO read/write pointers wrap modulo FIFO_DEPTH.
  - The count register is held explicitly, so full/empty are unambiguous.
- Reset values:
  - tx=1, state IDLE, FIFO empty (count=0, pointers=0), overflow=0, counters 0.
  - ReadData and MmioHit depend only on inputs and state; after reset a STATUS read returns 32'h0000_0004.
- Reset mid-frame: the frame is aborted, tx is high the cycle after the reset edge, and FIFO contents are discarded.
- Non-hit accesses: no state change, ReadData=0.
- Loads have no side effects.

Test Plan:
- Reset then read STATUS (ALUResult=32'hFFFF_0004) -> ReadData=32'h0000_0004, MmioHit=1, tx=1.
- With CLKS_PER_BIT=4, store 32'h0000_00A5 to 32'hFFFF_0000 -> START after 2 edges. tx sequence is 0, then 1,0,1,0,0,1,0,1, then stop 1, each held 4 cycles (40 cycles total). busy=1 throughout, then IDLE.
- Store 6 bytes 8'h01..8'h06 on consecutive cycles with FIFO_DEPTH=4 -> the first byte is popped in cycle 2, so 5 are accepted and 8'h06 is dropped. STATUS overflow=1 and full=1. Write STATUS -> overflow=0. The serial output shows 01..05 with a 1-cycle gap between frames.
- Push into a full FIFO in the same cycle as an IDLE pop -> push accepted, count stays 4, overflow stays 0.
- Assert reset during the DATA state of frame 1 with 2 bytes queued -> tx=1 the next cycle, STATUS=32'h0000_0004, no further frames are emitted.
- Store to 32'hFFFF_0008 and load 32'h0000_0100 -> MmioHit=0, ReadData=0, FIFO count unchanged.
